// File: rtl/table_order_terminal.sv
// Table-side ordering terminal: buffers keypad picks, sends them to the kitchen
// with reject/backoff retries, tracks unserved items and keeps the running bill.
module table_order_terminal #(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_RETRY  = 3,
  parameter int BACKOFF    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] key_item_i,
  input  logic       key_valid_i,
  output logic       key_overflow_o,
  output logic [1:0] order_item_o,
  output logic       order_valid_o,
  input  logic       order_reject_i,
  input  logic [1:0] ready_item_i,
  input  logic       item_ready_i,
  input  logic       checkout_req_i,
  output logic       checkout_done_o,
  output logic [7:0] final_bill_o,
  output logic [7:0] bill_total_o,
  output logic [4:0] pending_count_o,
  output logic [4:0] outstanding_count_o,
  output logic       order_dropped_o,
  output logic [1:0] dropped_item_o,
  output logic       spurious_ready_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_CHECK, ST_BACKOFF} state_e;

  state_e        state_q, state_d;
  logic [1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [4:0]    count_q, count_d;
  logic [4:0]    outstanding_q, outstanding_d;
  logic [3:0]    retry_q, retry_d;
  logic [3:0]    backoff_q, backoff_d;
  logic [7:0]    bill_q, bill_d;
  logic [7:0]    final_bill_q;
  logic [1:0]    order_item_q, dropped_item_q;
  logic          order_valid_q, key_overflow_q, order_dropped_q;
  logic          spurious_q, checkout_done_q, latch_q, latch_d;

  logic [1:0] head;
  logic       push, overflow, accept, drop, pop, serve, spurious, checkout_fire;

  // ready_item_i is informational only; the served count needs just the pulse.
  logic unused_ready_item;
  assign unused_ready_item = ^ready_item_i;

  assign head     = mem_q[rd_ptr_q];
  assign push     = key_valid_i && (count_q < 5'(FIFO_DEPTH));
  assign overflow = key_valid_i && !push;
  assign accept   = (state_q == ST_CHECK) && !order_reject_i;
  assign drop     = (state_q == ST_CHECK) && order_reject_i && (retry_q == 4'(MAX_RETRY));
  assign pop      = accept || drop;
  assign serve    = item_ready_i && (outstanding_q != 5'd0);
  assign spurious = item_ready_i && (outstanding_q == 5'd0);
  // A key arriving in the firing cycle still postpones the checkout.
  assign checkout_fire = latch_q && (state_q == ST_IDLE) && (count_q == 5'd0) &&
                         (outstanding_q == 5'd0) && !key_valid_i;

  always_comb begin
    state_d       = state_q;
    retry_d       = retry_q;
    backoff_d     = backoff_q;
    count_d       = count_q + 5'(push) - 5'(pop);
    outstanding_d = outstanding_q + 5'(accept) - 5'(serve);
    latch_d       = latch_q || checkout_req_i;
    bill_d        = bill_q;
    if (accept) bill_d = bill_q + 8'({6'b0, head}) + 8'd2;
    if (checkout_fire) begin
      bill_d  = 8'd0;
      latch_d = 1'b0;
    end
    unique case (state_q)
      ST_IDLE: if (count_q != 5'd0 && outstanding_q != 5'd31) state_d = ST_SEND;
      ST_SEND: state_d = ST_CHECK;
      ST_CHECK: begin
        if (accept || drop) begin
          retry_d = 4'd0;
          state_d = ST_IDLE;
        end else begin
          retry_d   = retry_q + 4'd1;
          backoff_d = 4'(BACKOFF);
          state_d   = ST_BACKOFF;
        end
      end
      ST_BACKOFF: begin
        backoff_d = backoff_q - 4'd1;
        if (backoff_q <= 4'd1) state_d = ST_SEND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= 5'd0;
      outstanding_q   <= 5'd0;
      retry_q         <= 4'd0;
      backoff_q       <= 4'd0;
      bill_q          <= 8'd0;
      final_bill_q    <= 8'd0;
      order_item_q    <= 2'd0;
      dropped_item_q  <= 2'd0;
      order_valid_q   <= 1'b0;
      key_overflow_q  <= 1'b0;
      order_dropped_q <= 1'b0;
      spurious_q      <= 1'b0;
      checkout_done_q <= 1'b0;
      latch_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      outstanding_q   <= outstanding_d;
      retry_q         <= retry_d;
      backoff_q       <= backoff_d;
      bill_q          <= bill_d;
      latch_q         <= latch_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      // The head cannot move while entering SEND, so it is safe to latch here.
      order_valid_q   <= (state_d == ST_SEND);
      order_item_q    <= (state_d == ST_SEND) ? head : 2'd0;
      key_overflow_q  <= overflow;
      order_dropped_q <= drop;
      if (drop) dropped_item_q <= head;
      spurious_q      <= spurious;
      checkout_done_q <= checkout_fire;
      if (checkout_fire) final_bill_q <= bill_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= key_item_i;
  end

  assign key_overflow_o      = key_overflow_q;
  assign order_item_o        = order_item_q;
  assign order_valid_o       = order_valid_q;
  assign checkout_done_o     = checkout_done_q;
  assign final_bill_o        = final_bill_q;
  assign bill_total_o        = bill_q;
  assign pending_count_o     = count_q;
  assign outstanding_count_o = outstanding_q;
  assign order_dropped_o     = order_dropped_q;
  assign dropped_item_o      = dropped_item_q;
  assign spurious_ready_o    = spurious_q;

endmodule

// File: tb/tb_table_order_terminal.sv
// Directed bench for table_order_terminal: ordering, retry/drop, overflow,
// served tracking, checkout and asynchronous reset.
module tb_table_order_terminal;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] key_item = 2'd0;
  logic       key_valid = 1'b0;
  logic       order_reject = 1'b0;
  logic [1:0] ready_item = 2'd0;
  logic       item_ready = 1'b0;
  logic       checkout_req = 1'b0;
  logic       key_overflow, order_valid, checkout_done, order_dropped, spurious_ready;
  logic [1:0] order_item, dropped_item;
  logic [7:0] final_bill, bill_total;
  logic [4:0] pending_count, outstanding_count;

  int checks = 0;
  int errors = 0;

  table_order_terminal dut (
    .clk                 (clk),
    .reset               (reset),
    .key_item_i          (key_item),
    .key_valid_i         (key_valid),
    .key_overflow_o      (key_overflow),
    .order_item_o        (order_item),
    .order_valid_o       (order_valid),
    .order_reject_i      (order_reject),
    .ready_item_i        (ready_item),
    .item_ready_i        (item_ready),
    .checkout_req_i      (checkout_req),
    .checkout_done_o     (checkout_done),
    .final_bill_o        (final_bill),
    .bill_total_o        (bill_total),
    .pending_count_o     (pending_count),
    .outstanding_count_o (outstanding_count),
    .order_dropped_o     (order_dropped),
    .dropped_item_o      (dropped_item),
    .spurious_ready_o    (spurious_ready)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic kv, input logic [1:0] ki, input logic rej,
                               input logic ir, input logic cr);
    key_valid    = kv;
    key_item     = ki;
    order_reject = rej;
    item_ready   = ir;
    checkout_req = cr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 8'(order_valid), 8'd0);
    checkOutput({tag, "_item"}, 8'(order_item), 8'd0);
    checkOutput({tag, "_pending"}, 8'(pending_count), 8'd0);
    checkOutput({tag, "_outst"}, 8'(outstanding_count), 8'd0);
    checkOutput({tag, "_bill"}, bill_total, 8'd0);
    checkOutput({tag, "_final"}, final_bill, 8'd0);
    checkOutput({tag, "_dropitem"}, 8'(dropped_item), 8'd0);
    checkOutput({tag, "_pulses"},
                8'({key_overflow, checkout_done, order_dropped, spurious_ready}), 8'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 1'b0;

    // Three accepted orders: sends 3 cycles apart, bill 2+3+4
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(k <= 3, 2'(k - 1), 1'b0, 1'b0, 1'b0);
      checkOutput("p1_valid", 8'(order_valid), 8'(k == 2 || k == 5 || k == 8));
      if (k == 2 || k == 5 || k == 8)
        checkOutput("p1_item", 8'(order_item), 8'((k - 2) / 3));
    end
    checkOutput("p1_bill", bill_total, 8'd9);
    checkOutput("p1_outst", 8'(outstanding_count), 8'd3);
    checkOutput("p1_pending", 8'(pending_count), 8'd0);

    // Checkout waits for all three items to be served
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("pa_done_early", 8'(checkout_done), 8'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("pa_outst", 8'(outstanding_count), 8'd0);
    checkOutput("pa_done_wait", 8'(checkout_done), 8'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("pa_done", 8'(checkout_done), 8'd1);
    checkOutput("pa_final", final_bill, 8'd9);
    checkOutput("pa_bill", bill_total, 8'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("pa_done_pulse", 8'(checkout_done), 8'd0);
    checkOutput("pa_final_hold", final_bill, 8'd9);

    // Item 3 rejected every time: four sends 6 cycles apart, then dropped
    for (int k = 1; k <= 26; k++) begin
      applyStimulus(k == 1, 2'd3, 1'b1, 1'b0, 1'b0);
      checkOutput("p2_valid", 8'(order_valid), 8'(k == 2 || k == 8 || k == 14 || k == 20));
      checkOutput("p2_dropped", 8'(order_dropped), 8'(k == 22));
    end
    checkOutput("p2_dropitem", 8'(dropped_item), 8'd3);
    checkOutput("p2_bill", bill_total, 8'd0);
    checkOutput("p2_outst", 8'(outstanding_count), 8'd0);
    checkOutput("p2_pending", 8'(pending_count), 8'd0);

    // Items 0 and 1 accepted (bill 5), checkout after two served items
    for (int k = 1; k <= 8; k++) applyStimulus(k <= 2, 2'(k - 1), 1'b0, 1'b0, 1'b0);
    checkOutput("p4_bill", bill_total, 8'd5);
    checkOutput("p4_outst", 8'(outstanding_count), 8'd2);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("p4_outst1", 8'(outstanding_count), 8'd1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("p4_outst0", 8'(outstanding_count), 8'd0);
    checkOutput("p4_done_wait", 8'(checkout_done), 8'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("p4_done", 8'(checkout_done), 8'd1);
    checkOutput("p4_final", final_bill, 8'd5);
    checkOutput("p4_bill0", bill_total, 8'd0);

    // Spurious ready, then accept coinciding with item_ready
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("p5_spurious", 8'(spurious_ready), 8'd1);
    checkOutput("p5_outst0", 8'(outstanding_count), 8'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("p5_spur_pulse", 8'(spurious_ready), 8'd0);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(k == 1 || k == 5, (k == 1) ? 2'd2 : 2'd3, 1'b0, k == 8, 1'b0);
      if (k == 4) checkOutput("p5_outst1", 8'(outstanding_count), 8'd1);
    end
    checkOutput("p5_outst_same", 8'(outstanding_count), 8'd1);
    checkOutput("p5_no_spur", 8'(spurious_ready), 8'd0);
    checkOutput("p5_bill", bill_total, 8'd9);

    // Overflow with the kitchen rejecting, so nothing pops
    for (int k = 1; k <= 14; k++) begin
      applyStimulus(k <= 9, 2'(k), 1'b1, 1'b0, 1'b0);
      checkOutput("p3_pending", 8'(pending_count), 8'((k < 8) ? k : 8));
      checkOutput("p3_overflow", 8'(key_overflow), 8'(k == 9));
    end
    checkOutput("p3_send", 8'(order_valid), 8'd1);

    // Asynchronous reset in the middle of a SEND cycle
    #2 reset = 1'b1;
    #1;
    checkAllZero("p6_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("p6_valid", 8'(order_valid), 8'd1);
    checkOutput("p6_item", 8'(order_item), 8'd1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("p6_bill", bill_total, 8'd3);
    checkOutput("p6_outst", 8'(outstanding_count), 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/table_order_terminal.md
# table_order_terminal

Table-side ordering terminal that drives one table port of the restaurant kitchen controller. It buffers customer keypad selections in a local FIFO and transmits them as single-cycle orders. On a kitchen reject it retries after a backoff. It also tracks accepted-but-unserved items from the kitchen's ready pulses and keeps a local running bill that is released at checkout.

## Interface
- FIFO_DEPTH, 8: keypad FIFO entries (power of two, max 16).
- MAX_RETRY, 3: rejected re-sends allowed before an order is dropped.
- BACKOFF, 4: idle cycles between a reject and the re-send (1..15).
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clock clk.
- key_item  in  2  keypad item code 0..3.
- key_valid  in  1  push key_item into the FIFO this cycle.
- key_overflow  out  1  one-cycle pulse: push refused because the FIFO was full.
- order_item  out  2  item presented to the kitchen.
- order_valid  out  1  order strobe to the kitchen.
- order_reject  in  1  kitchen reject, sampled one cycle after order_valid.
- ready_item  in  2  item completed by the kitchen (informational).
- item_ready  in  1  one-cycle pulse per completed item for this table.
- checkout_req  in  1  pulse: customer requests the bill.
- checkout_done  out  1  one-cycle pulse: final_bill is valid.
- final_bill  out  8  bill latched at checkout; holds until the next checkout.
- bill_total  out  8  running bill of accepted orders.
- pending_count  out  5  FIFO occupancy.
- outstanding_count  out  5  accepted orders not yet served.
- order_dropped  out  1  one-cycle pulse: order abandoned after retries.
- dropped_item  out  2  item code of the last dropped order.
- spurious_ready  out  1  one-cycle pulse: item_ready arrived with outstanding_count==0.

## Operation
- Reset value of every output is 0. FIFO, retry counter, backoff counter and checkout latch clear. FSM goes to IDLE.
- Price of item k is k+2. bill_total adds the price modulo 256, with no saturation, matching the kitchen-side bill.
- FIFO push: when key_valid is high and pending_count<FIFO_DEPTH, the item is written. If the FIFO is full, the item is discarded and key_overflow pulses. This holds even if a pop happens in the same cycle. A push and a pop in the same cycle leave pending_count unchanged.
- FSM states are IDLE, SEND, CHECK and BACKOFF.
- IDLE: go to SEND when the FIFO is non-empty and outstanding_count<31. Otherwise stay in IDLE.
- SEND: order_valid=1 and order_item=FIFO head for exactly this cycle. Then go to CHECK.
- CHECK: order_valid=0 and order_reject is sampled.
  - order_reject=0 (accept): pop the head, add the price to bill_total, increment outstanding_count, clear the retry counter, go to IDLE.
  - order_reject=1 and retries<MAX_RETRY: increment retries, load the backoff counter with BACKOFF, go to BACKOFF.
  - order_reject=1 and retries==MAX_RETRY: pop the head, pulse order_dropped, set dropped_item=head, clear retries, go to IDLE. No bill change.
- BACKOFF: decrement the counter each cycle. When it reaches 0, go to SEND and re-send the same head item.
- Served tracking: on item_ready with outstanding_count>0, decrement outstanding_count. On item_ready with outstanding_count==0, pulse spurious_ready and leave the count unchanged. If an accept and item_ready land in the same cycle, outstanding_count is unchanged.
- Checkout: checkout_req sets a pending latch. Checkout fires when the latch is set, the FSM is in IDLE, pending_count==0 and outstanding_count==0. On that cycle: final_bill<=bill_total, bill_total<=0, checkout_done pulses, latch clears.
  - Keys arriving while checkout is pending are accepted and postpone the checkout.
  - Repeated checkout_req pulses while the latch is set have no extra effect.
- Reset mid-operation: order_valid drops immediately (asynchronous). An in-flight order is forgotten and the kitchen's response is ignored.

## Timing
- Minimum order spacing is 3 cycles (IDLE, SEND, CHECK). A key pushed at edge N gives order_valid high in cycle N+2 at the earliest.
- Reject path: order_valid is high in SEND cycle S. The re-send is in cycle S+2+BACKOFF.
- Worst case for one item: (MAX_RETRY+1) sends before the drop.
- All outputs are registered. Pulses last exactly one cycle.
- checkout_done is asserted on the cycle after the last condition becomes true. final_bill is valid in that same cycle.

## Test plan
- Reset, push items 0,1,2 on consecutive cycles with no rejects → order_valid in cycles 2,5,8 carrying 0,1,2. bill_total=9, outstanding_count=3, pending_count=0.
- Push item 3 with order_reject held high, MAX_RETRY=3, BACKOFF=4 → 4 sends spaced 6 cycles apart, then order_dropped with dropped_item=3. bill_total unchanged, outstanding_count=0.
- Push 9 keys back-to-back with no kitchen responses needed (FIFO_DEPTH=8) → key_overflow pulses on the 9th push, or on the first push that finds the FIFO full. pending_count never exceeds 8.
- Accept items 0 and 1 (bill 5). Assert checkout_req. Deliver item_ready twice → checkout_done one cycle after the second item_ready. final_bill=5, bill_total=0.
- item_ready with outstanding_count==0 → spurious_ready pulse, count stays 0. An accept coinciding with item_ready with outstanding_count=1 → count stays 1.
- Assert reset during a SEND cycle → order_valid low in the same cycle, all outputs 0. The next push is sent normally.
